// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous imem, steers with same-cycle prediction.
// Latency: address issued in cycle N is presented on if_* in cycle N+1; one instruction per cycle.
// Backpressure: stall freezes the PC and F1, and the in-flight imem word is parked in a hold register.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [15:0]      redirect_pc,
    input  logic             pred_taken,
    input  logic [15:0]      pred_pc,
    output logic [15:0]      current_pc,
    output logic [15:0]      imem_addr,
    input  logic [15:0]      imem_rdata,
    output logic             if_valid,
    output logic [15:0]      if_instr,
    output logic [15:0]      if_pc,
    output logic             if_pred_taken,
    output logic [15:0]      if_pred_pc,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [15:0]      pc_reg;
    logic [15:0]      pc_seq;
    logic             req_valid;
    logic [15:0]      req_pc;
    logic             req_pred_taken;
    logic [15:0]      req_pred_pc;
    logic             hold_valid;
    logic [15:0]      hold_instr;
    logic [CNT_W-1:0] fetch_count_r;
    logic [CNT_W-1:0] redirect_count_r;

    assign pc_seq     = pc_reg + 16'(PC_STEP);
    assign current_pc = pc_reg;
    assign imem_addr  = pc_reg;

    // F0: next-PC selection, redirect beats stall beats prediction.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            pc_reg <= redirect_pc;
        end else if (!stall) begin
            pc_reg <= pred_taken ? pred_pc : pc_seq;
        end
    end

    // F1: request metadata plus the hold register for the word that arrives during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid      <= 1'b0;
            req_pc         <= 16'h0000;
            req_pred_taken <= 1'b0;
            req_pred_pc    <= 16'h0000;
            hold_valid     <= 1'b0;
            hold_instr     <= 16'h0000;
        end else if (redirect_valid) begin
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
        end else if (!stall) begin
            req_valid      <= 1'b1;
            req_pc         <= pc_reg;
            req_pred_taken <= pred_taken;
            req_pred_pc    <= pred_taken ? pred_pc : pc_seq;
            hold_valid     <= 1'b0;
        end else if (req_valid && !hold_valid) begin
            // After this edge imem is re-reading pc_reg, so park the word that belongs to req_pc.
            hold_instr <= imem_rdata;
            hold_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_r    <= '0;
            redirect_count_r <= '0;
        end else begin
            if (if_valid && !stall && fetch_count_r != CNT_MAX) begin
                fetch_count_r <= fetch_count_r + 1'b1;
            end
            if (redirect_valid && redirect_count_r != CNT_MAX) begin
                redirect_count_r <= redirect_count_r + 1'b1;
            end
        end
    end

    assign if_valid       = req_valid & ~redirect_valid;
    assign if_instr       = hold_valid ? hold_instr : imem_rdata;
    assign if_pc          = req_pc;
    assign if_pred_taken  = req_pred_taken;
    assign if_pred_pc     = req_pred_pc;
    assign fetch_count    = fetch_count_r;
    assign redirect_count = redirect_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous imem model returning addr ^ 16'hA5A5.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        pred_taken;
    logic [15:0] pred_pc;
    logic [15:0] current_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_pred_taken;
    logic [15:0] if_pred_pc;
    logic [15:0] fetch_count;
    logic [15:0] redirect_count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(2), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .current_pc     (current_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_pc     (if_pred_pc),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_addr ^ 16'hA5A5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        pred_taken = 1'b0; pred_pc = 16'h0000;
        tick(); tick();
        settle();
        chk("rst_pc", current_pc, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_vld", {15'b0, if_valid}, 16'h0000);
        chk("rst_fcnt", fetch_count, 16'h0000);
        chk("rst_rcnt", redirect_count, 16'h0000);

        // c1: first issue after reset
        reset = 1'b0; settle();
        chk("c1_pc", current_pc, 16'h0000);
        chk("c1_vld", {15'b0, if_valid}, 16'h0000);
        tick(); settle();
        chk("c2_pc", current_pc, 16'h0002);
        chk("c2_vld", {15'b0, if_valid}, 16'h0001);
        chk("c2_ifpc", if_pc, 16'h0000);
        chk("c2_instr", if_instr, 16'hA5A5);
        tick(); settle();
        chk("c3_pc", current_pc, 16'h0004);
        chk("c3_ifpc", if_pc, 16'h0002);
        chk("c3_instr", if_instr, 16'hA5A7);
        chk("c3_fcnt", fetch_count, 16'h0001);
        tick(); settle();
        chk("c4_pc", current_pc, 16'h0006);
        chk("c4_ifpc", if_pc, 16'h0004);
        chk("c4_instr", if_instr, 16'hA5A1);
        chk("c4_ppc", if_pred_pc, 16'h0006);

        // c5..c7: stall while if_pc = 6
        tick(); stall = 1'b1; settle();
        chk("c5_pc", current_pc, 16'h0008);
        chk("c5_ifpc", if_pc, 16'h0006);
        chk("c5_instr", if_instr, 16'hA5A3);
        chk("c5_fcnt", fetch_count, 16'h0003);
        tick(); settle();
        chk("c6_rdata", imem_rdata, 16'hA5AD);
        chk("c6_instr", if_instr, 16'hA5A3);
        chk("c6_pc", current_pc, 16'h0008);
        chk("c6_fcnt", fetch_count, 16'h0003);
        tick(); settle();
        chk("c7_instr", if_instr, 16'hA5A3);
        chk("c7_fcnt", fetch_count, 16'h0003);
        tick(); stall = 1'b0; settle();
        chk("c8_instr", if_instr, 16'hA5A3);
        chk("c8_ifpc", if_pc, 16'h0006);
        tick(); settle();
        chk("c9_ifpc", if_pc, 16'h0008);
        chk("c9_instr", if_instr, 16'hA5AD);
        chk("c9_fcnt", fetch_count, 16'h0004);
        tick(); stall = 1'b1; settle();
        chk("c10_ifpc", if_pc, 16'h000A);
        chk("c10_instr", if_instr, 16'hA5AF);
        chk("c10_fcnt", fetch_count, 16'h0005);

        // c11: redirect during a stall with the hold register full
        tick(); redirect_valid = 1'b1; redirect_pc = 16'h0100; settle();
        chk("c11_vld", {15'b0, if_valid}, 16'h0000);
        chk("c11_instr", if_instr, 16'hA5AF);
        tick(); redirect_valid = 1'b0; stall = 1'b0; settle();
        chk("c12_pc", current_pc, 16'h0100);
        chk("c12_vld", {15'b0, if_valid}, 16'h0000);
        chk("c12_rcnt", redirect_count, 16'h0001);
        chk("c12_fcnt", fetch_count, 16'h0005);
        tick(); settle();
        chk("c13_ifpc", if_pc, 16'h0100);
        chk("c13_vld", {15'b0, if_valid}, 16'h0001);
        chk("c13_instr", if_instr, 16'hA4A5);

        // c13: redirect to 4 alongside a prediction; redirect must win
        redirect_valid = 1'b1; redirect_pc = 16'h0004; pred_taken = 1'b1; pred_pc = 16'h0200; settle();
        chk("c13_kill", {15'b0, if_valid}, 16'h0000);
        tick(); redirect_valid = 1'b0; pred_pc = 16'h0020; settle();
        chk("c14_pc", current_pc, 16'h0004);
        chk("c14_rcnt", redirect_count, 16'h0002);
        chk("c14_fcnt", fetch_count, 16'h0005);
        tick(); pred_taken = 1'b0; settle();
        chk("c15_pc", current_pc, 16'h0020);
        chk("c15_ifpc", if_pc, 16'h0004);
        chk("c15_pt", {15'b0, if_pred_taken}, 16'h0001);
        chk("c15_ppc", if_pred_pc, 16'h0020);
        chk("c15_instr", if_instr, 16'hA5A1);
        tick(); settle();
        chk("c16_ifpc", if_pc, 16'h0020);
        chk("c16_pt", {15'b0, if_pred_taken}, 16'h0000);
        chk("c16_ppc", if_pred_pc, 16'h0022);
        chk("c16_fcnt", fetch_count, 16'h0006);

        // wrap: redirect to FFFE
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE; settle();
        tick(); redirect_valid = 1'b0; settle();
        chk("w1_pc", current_pc, 16'hFFFE);
        chk("w1_rcnt", redirect_count, 16'h0003);
        tick(); settle();
        chk("w2_pc", current_pc, 16'h0000);
        chk("w2_ifpc", if_pc, 16'hFFFE);
        chk("w2_instr", if_instr, 16'h5A5B);
        chk("w2_ppc", if_pred_pc, 16'h0000);

        // saturation: preload fetch_count during a stall, then accept one
        tick(); stall = 1'b1;
        force dut.fetch_count_r = 16'hFFFF;
        settle();
        release dut.fetch_count_r;
        settle();
        chk("s1_ifpc", if_pc, 16'h0000);
        tick(); stall = 1'b0; settle();
        chk("s2_vld", {15'b0, if_valid}, 16'h0001);
        chk("s2_instr", if_instr, 16'hA5A5);
        chk("s2_fcnt", fetch_count, 16'hFFFF);
        tick(); settle();
        chk("s3_fcnt", fetch_count, 16'hFFFF);
        chk("s3_ifpc", if_pc, 16'h0002);

        // reset mid-run, also beating a redirect
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0300; settle();
        tick(); reset = 1'b0; redirect_valid = 1'b0; settle();
        chk("r_pc", current_pc, 16'h0000);
        chk("r_vld", {15'b0, if_valid}, 16'h0000);
        chk("r_fcnt", fetch_count, 16'h0000);
        chk("r_rcnt", redirect_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the 16-bit pipeline. It owns the PC register and drives the synchronous instruction memory (1-cycle read latency). It steers the next PC using the branch predictor's same-cycle prediction, and accepts redirects from execute on mispredict. It delivers the fetched instruction with its PC and prediction metadata to decode, holds it across decode stalls, and keeps saturating performance counters.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset.
PC_STEP, 2, sequential PC increment in bytes.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept this cycle; hold stage
redirect_valid  input  1  execute resolved a mispredict; load redirect_pc
redirect_pc  input  16  correct next PC from execute
pred_taken  input  1  predictor says current_pc is a taken branch
pred_pc  input  16  predicted target for current_pc
current_pc  output  16  PC being issued this cycle (to predictor)
imem_addr  output  16  instruction memory address (= current_pc)
imem_rdata  input  16  memory data, valid one cycle after imem_addr
if_valid  output  1  instruction to decode is valid
if_instr  output  16  instruction word
if_pc  output  16  PC of if_instr
if_pred_taken  output  1  prediction recorded for if_instr
if_pred_pc  output  16  predicted next PC recorded for if_instr
fetch_count  output  CNT_W  instructions accepted by decode
redirect_count  output  CNT_W  redirects taken

Behaviour:
- Two internal stages. F0: pc_reg drives current_pc and imem_addr combinationally. F1: req_valid, req_pc, req_pred_taken, req_pred_pc, hold_valid, hold_instr.
- Reset values: pc_reg = RESET_PC; req_valid = 0; req_pc = 0; req_pred_taken = 0; req_pred_pc = 0; hold_valid = 0; hold_instr = 0; both counters = 0. if_valid is therefore 0 during and after reset until the first issue completes.
- Next-PC priority, highest first:
  - redirect_valid: pc_reg <= redirect_pc.
  - stall: pc_reg holds.
  - pred_taken: pc_reg <= pred_pc.
  - otherwise: pc_reg <= pc_reg + PC_STEP (16-bit wrap, FFFE+2 = 0000).
- F1 capture:
  - On redirect_valid: req_valid <= 0 and hold_valid <= 0. The in-flight instruction is younger than the branch and is killed.
  - Else if stall=0: req_valid <= 1; req_pc <= pc_reg; req_pred_taken <= pred_taken; req_pred_pc <= (pred_taken ? pred_pc : pc_reg+PC_STEP).
  - Else (stall=1): F1 holds.
- Holding register: the address stays at pc_reg during a stall, so imem_rdata no longer belongs to req_pc.
  - First stall cycle with req_valid=1 and hold_valid=0: hold_instr <= imem_rdata; hold_valid <= 1.
  - hold_valid clears on the first cycle with stall=0, or on redirect.
- Outputs:
  - if_valid = req_valid & ~redirect_valid.
  - if_instr = hold_valid ? hold_instr : imem_rdata.
  - if_pc, if_pred_taken and if_pred_pc come from the F1 registers.
- Latency: address issued in cycle N appears on if_* in cycle N+1. With no stalls, throughput is one instruction per cycle.
- Redirect during stall: redirect wins. Next cycle pc_reg = redirect_pc, if_valid = 0, and the held instruction is discarded.
- Redirect while pred_taken is asserted: redirect wins and the prediction is ignored.
- Counters:
  - fetch_count increments when if_valid & ~stall.
  - redirect_count increments when redirect_valid.
  - Both saturate at all-ones and clear only on reset.
- Reset asserted mid-operation overrides everything: next cycle pc_reg = RESET_PC and F1 is invalid.

Test Plan:
- Reset then run 4 cycles, memory returns mem[a] = a^16'hA5A5, pred_taken=0 -> current_pc 0,2,4,6; if_valid from cycle 2; if_pc 0,2,4 with if_instr A5A5,A5A7,A5A1; fetch_count=3.
- At current_pc=0x0004, pred_taken=1 and pred_pc=0x0020 -> next current_pc=0x0020; the instruction with if_pc=0x0004 shows if_pred_taken=1 and if_pred_pc=0x0020.
- stall for 3 cycles while if_pc=0x0006 -> if_instr stays mem[6] for all 3 cycles despite imem_rdata changing; current_pc frozen at 0x0008; after release, if_pc sequence continues 0x0008, 0x000A; fetch_count does not increment during the stall.
- redirect_valid with redirect_pc=0x0100 while stall=1 and hold_valid=1 -> that cycle if_valid=0; next cycle current_pc=0x0100; following cycle if_pc=0x0100; redirect_count=1.
- PC wrap: redirect to 0xFFFE, no stalls -> current_pc 0xFFFE then 0x0000.
- Preload fetch_count to all-ones by force, accept one instruction -> it stays 0xFFFF; assert reset mid-run -> counters 0, current_pc = RESET_PC, if_valid = 0.
